// File: rtl/adma_dm_axi_ar.sv
// Read-address issuer: round-robin picks a channel descriptor, splits it into INCR bursts
// (<= ATX_MAX_LEN beats, never crossing 4KB), drives AXI AR and pushes {chn,id,len} to the R stage.
module adma_dm_axi_ar #(
   parameter int DMA_CHN_NUM    = 4,
   parameter int MST_ID_W       = 5,
   parameter int SRC_ADDR_W     = 32,
   parameter int ATX_LEN_W      = 8,
   parameter int ATX_SIZE_W     = 3,
   parameter int ATX_SRC_DATA_W = 256,
   parameter int ATX_MAX_LEN    = 16,
   parameter int XFER_LEN_W     = 16,
   parameter int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DMA_CHN_NUM-1:0]            req_vld,
   output logic [DMA_CHN_NUM-1:0]            req_rdy,
   input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0] req_addr,
   input  logic [DMA_CHN_NUM*XFER_LEN_W-1:0] req_len,
   input  logic [DMA_CHN_NUM*MST_ID_W-1:0]   atx_id,
   output logic [DMA_CHN_NUM-1:0]            chn_done,
   output logic [DMA_CHN_NUM_W-1:0]          atx_chn_id,
   output logic [MST_ID_W-1:0]               atx_arid,
   output logic [ATX_LEN_W-1:0]              atx_arlen,
   output logic                              atx_vld,
   input  logic                              atx_rdy,
   output logic [MST_ID_W-1:0]               m_arid_o,
   output logic [SRC_ADDR_W-1:0]             m_araddr_o,
   output logic [ATX_LEN_W-1:0]              m_arlen_o,
   output logic [ATX_SIZE_W-1:0]             m_arsize_o,
   output logic [1:0]                        m_arburst_o,
   output logic                              m_arvalid_o,
   input  logic                              m_arready_i
);
   localparam int BEAT_B = ATX_SRC_DATA_W / 8;
   localparam int BSH    = $clog2(BEAT_B);
   localparam int LW     = XFER_LEN_W + 1;
   localparam int CW     = DMA_CHN_NUM_W;

   typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           rr_q, rr_d, cur_chn_q, cur_chn_d;
   logic [SRC_ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [XFER_LEN_W-1:0]   rem_q, rem_d;
   logic [MST_ID_W-1:0]     cur_id_q, cur_id_d;
   logic [LW-1:0]           beats_q, beats_d;
   logic [ATX_LEN_W-1:0]    arlen_q, arlen_d;
   logic                    ar_done_q, ar_done_d, atx_done_q, atx_done_d;
   logic [DMA_CHN_NUM-1:0]  chn_done_q, chn_done_d;

   logic                    gnt_found;
   logic [CW-1:0]           gnt_idx;
   logic [LW-1:0]           bnd, rem_ext, max_ext, min_rm, beats_c;
   logic                    ar_hs, atx_hs;

   // Walk from the highest offset down so the lowest offset from rr_q wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = DMA_CHN_NUM - 1; i >= 0; i--) begin
         if (req_vld[(int'(rr_q) + i) % DMA_CHN_NUM]) begin
            gnt_found = 1'b1;
            gnt_idx   = CW'((int'(rr_q) + i) % DMA_CHN_NUM);
         end
      end
   end

   // Beats left before the next 4KB boundary, at full width so nothing truncates before the min.
   assign bnd     = LW'((13'd4096 - {1'b0, cur_addr_q[11:0]}) >> BSH);
   assign rem_ext = LW'(rem_q);
   assign max_ext = LW'(ATX_MAX_LEN);
   assign min_rm  = (rem_ext < max_ext) ? rem_ext : max_ext;
   assign beats_c = (min_rm < bnd) ? min_rm : bnd;

   assign ar_hs  = m_arvalid_o & m_arready_i;
   assign atx_hs = atx_vld & atx_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         cur_chn_q  <= '0;
         cur_addr_q <= '0;
         rem_q      <= '0;
         cur_id_q   <= '0;
         beats_q    <= '0;
         arlen_q    <= '0;
         ar_done_q  <= 1'b0;
         atx_done_q <= 1'b0;
         chn_done_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         cur_chn_q  <= cur_chn_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         cur_id_q   <= cur_id_d;
         beats_q    <= beats_d;
         arlen_q    <= arlen_d;
         ar_done_q  <= ar_done_d;
         atx_done_q <= atx_done_d;
         chn_done_q <= chn_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      cur_chn_d  = cur_chn_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      cur_id_d   = cur_id_q;
      beats_d    = beats_q;
      arlen_d    = arlen_q;
      ar_done_d  = ar_done_q;
      atx_done_d = atx_done_q;
      chn_done_d = '0;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               cur_chn_d  = gnt_idx;
               cur_addr_d = req_addr[gnt_idx*SRC_ADDR_W +: SRC_ADDR_W];
               rem_d      = req_len[gnt_idx*XFER_LEN_W +: XFER_LEN_W];
               cur_id_d   = atx_id[gnt_idx*MST_ID_W +: MST_ID_W];
               rr_d       = (gnt_idx == CW'(DMA_CHN_NUM - 1)) ? '0 : gnt_idx + 1'b1;
               if (rem_d == '0) chn_done_d[gnt_idx] = 1'b1;
               else             state_d = CALC;
            end
         end
         CALC: begin
            beats_d = beats_c;
            arlen_d = ATX_LEN_W'(beats_c - 1'b1);
            state_d = ISSUE;
         end
         ISSUE: begin
            ar_done_d  = ar_done_q | ar_hs;
            atx_done_d = atx_done_q | atx_hs;
            if (ar_done_d && atx_done_d) begin
               cur_addr_d = cur_addr_q + (SRC_ADDR_W'(beats_q) << BSH);
               rem_d      = rem_q - beats_q[XFER_LEN_W-1:0];
               ar_done_d  = 1'b0;
               atx_done_d = 1'b0;
               if (rem_d == '0) begin
                  chn_done_d[cur_chn_q] = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // req_rdy is combinational from req_vld, so it must be masked while reset is held.
   always_comb begin
      req_rdy = '0;
      if (state_q == IDLE && gnt_found && !rst) req_rdy[gnt_idx] = 1'b1;
      m_arvalid_o = (state_q == ISSUE) && !ar_done_q;
      atx_vld     = (state_q == ISSUE) && !atx_done_q;
   end

   assign chn_done    = chn_done_q;
   assign atx_chn_id  = cur_chn_q;
   assign atx_arid    = cur_id_q;
   assign atx_arlen   = arlen_q;
   assign m_arid_o    = cur_id_q;
   assign m_araddr_o  = cur_addr_q;
   assign m_arlen_o   = arlen_q;
   assign m_arsize_o  = ATX_SIZE_W'(BSH);
   assign m_arburst_o = 2'b01;

endmodule

// File: tb/tb_adma_dm_axi_ar.sv
// Directed bench for adma_dm_axi_ar: burst-splitting vector table plus hand sequences
// for arbitration, AR backpressure, mid-burst reset and zero-length descriptors.
module tb_adma_dm_axi_ar;
   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_vld, req_rdy, chn_done;
   logic [127:0]  req_addr;
   logic [63:0]   req_len;
   logic [19:0]   atx_id;
   logic [1:0]    atx_chn_id;
   logic [4:0]    atx_arid, m_arid_o;
   logic [7:0]    atx_arlen, m_arlen_o;
   logic          atx_vld, atx_rdy, m_arvalid_o, m_arready_i;
   logic [31:0]   m_araddr_o;
   logic [2:0]    m_arsize_o;
   logic [1:0]    m_arburst_o;

   logic [4:0] id_of [4] = '{5'd3, 5'd17, 5'd9, 5'd22};

   always #5 clk = ~clk;

   adma_dm_axi_ar dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
      .req_len(req_len), .atx_id(atx_id), .chn_done(chn_done), .atx_chn_id(atx_chn_id),
      .atx_arid(atx_arid), .atx_arlen(atx_arlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
      .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
      .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o),
      .m_arready_i(m_arready_i)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      req_vld = '0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Present one descriptor at a negedge, check the grant, complete the handshake.
   task automatic drive_desc(input int c, input logic [31:0] a, input logic [15:0] l);
      @(negedge clk);
      req_vld = '0;
      req_vld[c] = 1'b1;
      req_addr[c*32 +: 32] = a;
      req_len[c*16 +: 16] = l;
      #1 check("req_rdy_grant", req_rdy, 64'(1 << c));
      @(posedge clk);
      @(negedge clk);
      req_vld = '0;
   endtask

   // From the negedge after a handshake, the next valid must appear one negedge later.
   task automatic wait_valid(input string name);
      int cnt = 0;
      while (!m_arvalid_o && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check(name, 64'(cnt), 64'd1);
   endtask

   task automatic wait_grant(input logic [3:0] exp);
      int cnt = 0;
      logic [3:0] g;
      #1;
      while (req_rdy == '0 && cnt < 50) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      g = req_rdy;
      check("rr_grant", 64'(g), 64'(exp));
      @(posedge clk);
      @(negedge clk);
      req_vld = req_vld & ~g;
   endtask

   typedef struct {
      int          chn;
      logic [31:0] addr;
      logic [15:0] len;
      int          nb;
      logic [31:0] a0, a1, a2;
      logic [7:0]  l0, l1, l2;
   } vec_t;

   vec_t vt[5];

   initial begin
      vt[0] = '{0, 32'h0000_1000, 16'd40, 3, 32'h1000, 32'h1200, 32'h1400, 8'd15, 8'd15, 8'd7};
      vt[1] = '{1, 32'h0000_1F80, 16'd10, 2, 32'h1F80, 32'h2000, 32'h0,    8'd3,  8'd5,  8'd0};
      vt[2] = '{2, 32'h0000_0FE0, 16'd3,  2, 32'h0FE0, 32'h1000, 32'h0,    8'd0,  8'd1,  8'd0};
      vt[3] = '{3, 32'h0002_0000, 16'd16, 1, 32'h20000, 32'h0,   32'h0,    8'd15, 8'd0,  8'd0};
      vt[4] = '{1, 32'h0000_3000, 16'd17, 2, 32'h3000, 32'h3200, 32'h0,    8'd15, 8'd0,  8'd0};

      atx_id = {id_of[3], id_of[2], id_of[1], id_of[0]};
      req_addr = {4{32'h0000_0400}};
      req_len  = {4{16'd4}};
      atx_rdy = 1'b1;
      m_arready_i = 1'b1;

      // Reset state, with every channel requesting while reset is held.
      rst = 1'b1;
      req_vld = 4'b1111;
      @(negedge clk);
      check("rst_req_rdy", req_rdy, 0);
      check("rst_chn_done", chn_done, 0);
      check("rst_arvalid", m_arvalid_o, 0);
      check("rst_atx_vld", atx_vld, 0);
      check("rst_araddr", m_araddr_o, 0);
      check("rst_arlen", m_arlen_o, 0);
      check("rst_arid", m_arid_o, 0);
      check("arburst", m_arburst_o, 2'b01);
      check("arsize", m_arsize_o, 3'd5);
      req_vld = '0;
      @(negedge clk);
      rst = 1'b0;

      // Burst-splitting vectors with both ready inputs held high.
      for (int v = 0; v < 5; v++) begin
         logic [31:0] ea[3];
         logic [7:0]  el[3];
         ea = '{vt[v].a0, vt[v].a1, vt[v].a2};
         el = '{vt[v].l0, vt[v].l1, vt[v].l2};
         drive_desc(vt[v].chn, vt[v].addr, vt[v].len);
         for (int b = 0; b < vt[v].nb; b++) begin
            wait_valid("vec_latency");
            check("vec_araddr", m_araddr_o, ea[b]);
            check("vec_arlen", m_arlen_o, el[b]);
            check("vec_atx_arlen", atx_arlen, el[b]);
            check("vec_atx_vld", atx_vld, 1);
            check("vec_arid", m_arid_o, id_of[vt[v].chn]);
            check("vec_atx_arid", atx_arid, id_of[vt[v].chn]);
            check("vec_atx_chn_id", atx_chn_id, 64'(vt[v].chn));
            @(posedge clk);
            @(negedge clk);
            check("vec_chn_done", chn_done,
                  (b == vt[v].nb - 1) ? 64'(1 << vt[v].chn) : 64'd0);
         end
      end

      // Round-robin arbitration from a fresh pointer.
      do_reset();
      req_len = {4{16'd1}};
      req_addr = {32'h700, 32'h600, 32'h200, 32'h100};
      req_vld = 4'b0101;
      wait_grant(4'b0001);
      wait_grant(4'b0100);
      req_vld = 4'b0011;
      wait_grant(4'b0001);
      wait_grant(4'b0010);
      req_vld = 4'b1001;
      wait_grant(4'b1000);
      wait_grant(4'b0001);

      // ARREADY held low while the ATX record is accepted at once.
      do_reset();
      atx_rdy = 1'b1;
      m_arready_i = 1'b0;
      drive_desc(0, 32'h1000, 16'd20);
      wait_valid("stall_latency");
      check("stall_atx_vld_first", atx_vld, 1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("stall_arvalid", m_arvalid_o, 1);
         check("stall_araddr", m_araddr_o, 32'h1000);
         check("stall_arlen", m_arlen_o, 8'd15);
         check("stall_atx_vld", atx_vld, 0);
      end
      m_arready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_valid("stall_next_latency");
      check("stall2_araddr", m_araddr_o, 32'h1200);
      check("stall2_arlen", m_arlen_o, 8'd3);
      check("stall2_atx_vld", atx_vld, 1);
      @(posedge clk);
      @(negedge clk);
      check("stall_chn_done", chn_done, 4'b0001);

      // Reset asserted while AR is pending mid-descriptor.
      atx_rdy = 1'b0;
      m_arready_i = 1'b0;
      drive_desc(1, 32'h4000, 16'd40);
      wait_valid("rstmid_latency");
      @(negedge clk);
      rst = 1'b1;
      req_vld[2] = 1'b1;
      #1;
      check("rstmid_arvalid", m_arvalid_o, 0);
      check("rstmid_atx_vld", atx_vld, 0);
      check("rstmid_req_rdy", req_rdy, 0);
      @(negedge clk);
      req_vld = '0;
      rst = 1'b0;
      atx_rdy = 1'b1;
      m_arready_i = 1'b1;
      begin
         int act = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_arvalid_o || atx_vld) act++;
         end
         check("rstmid_idle_after", 64'(act), 0);
      end

      // Zero-length descriptor: handshake and done pulse, no bursts.
      drive_desc(3, 32'h5000, 16'd0);
      check("zero_chn_done", chn_done, 4'b1000);
      check("zero_arvalid", m_arvalid_o, 0);
      check("zero_atx_vld", atx_vld, 0);
      begin
         int act = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m_arvalid_o || atx_vld || chn_done != '0) act++;
         end
         check("zero_quiet_after", 64'(act), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/adma_dm_axi_ar.md
Name: adma_dm_axi_ar

Overview:
Read-address issuer of the AXI DMA data mover. It sits directly upstream of the R-channel stage. It takes per-channel read descriptors (source address, beat count) and arbitrates between channels round-robin. Each descriptor is split into INCR bursts that never exceed ATX_MAX_LEN beats or cross a 4KB boundary. For every burst it drives the AXI AR channel and, in parallel, pushes the transaction record {chn_id, arid, arlen} to the R stage's atx_* input.

Parameters:
DMA_CHN_NUM, 4, number of DMA channels
MST_ID_W, 5, AXI ID width
SRC_ADDR_W, 32, source address width
ATX_LEN_W, 8, AXI ARLEN width
ATX_SIZE_W, 3, AXI ARSIZE width
ATX_SRC_DATA_W, 256, source data width; beat size B = ATX_SRC_DATA_W/8 bytes
ATX_MAX_LEN, 16, maximum beats per burst (1..2^ATX_LEN_W)
XFER_LEN_W, 16, width of descriptor beat count
DMA_CHN_NUM_W, $clog2(DMA_CHN_NUM), derived; do not set

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_vld  in  [DMA_CHN_NUM]  per-channel descriptor valid
req_rdy  out  [DMA_CHN_NUM]  per-channel descriptor accept (at most one bit high)
req_addr  in  SRC_ADDR_W x DMA_CHN_NUM  start address; must be B-aligned
req_len  in  XFER_LEN_W x DMA_CHN_NUM  total beats (0 = no-op)
atx_id  in  MST_ID_W x DMA_CHN_NUM  ARID used by each channel
chn_done  out  [DMA_CHN_NUM]  1-cycle pulse when a channel's last burst is fully issued
atx_chn_id  out  DMA_CHN_NUM_W  channel of the current burst
atx_arid  out  MST_ID_W  ARID of the current burst
atx_arlen  out  ATX_LEN_W  beats-1 of the current burst
atx_vld  out  1  transaction record valid
atx_rdy  in  1  transaction record accept
m_arid_o  out  MST_ID_W  AXI ARID
m_araddr_o  out  SRC_ADDR_W  AXI ARADDR
m_arlen_o  out  ATX_LEN_W  AXI ARLEN
m_arsize_o  out  ATX_SIZE_W  constant $clog2(B)
m_arburst_o  out  2  constant 2'b01 (INCR)
m_arvalid_o  out  1  AXI ARVALID
m_arready_i  in  1  AXI ARREADY

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; RR pointer = 0.
  - req_rdy, chn_done, atx_vld and m_arvalid_o are 0 immediately.
  - Address, length and ID registers are cleared to 0.
- FSM has three states: IDLE, CALC, ISSUE.
- IDLE:
  - Grant the first channel with req_vld set, searching from the RR pointer upward with wrap.
  - req_rdy[g] is driven combinationally in the same cycle; that is the handshake.
  - Latch cur_chn=g, cur_addr=req_addr[g], rem=req_len[g], cur_id=atx_id[g].
  - RR pointer becomes g+1 (mod DMA_CHN_NUM).
  - If req_len[g]==0: pulse chn_done[g] next cycle, stay in IDLE, issue no AR.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - bnd = (4096 - cur_addr[11:0]) >> $clog2(B).
  - beats = min(rem, ATX_MAX_LEN, bnd). Computed at width XFER_LEN_W+1; no truncation before the min.
  - Register arlen = beats-1. Go to ISSUE.
- ISSUE:
  - m_arvalid_o and atx_vld both rise in the same cycle: two cycles after the req handshake.
  - Payload: m_araddr_o = cur_addr; m_arlen_o = atx_arlen = beats-1; m_arid_o = atx_arid = cur_id; atx_chn_id = cur_chn.
  - AR and ATX handshakes are independent. Sticky flags ar_done / atx_done are set on each handshake. A valid drops the cycle after its own handshake and is never reasserted for the same burst.
  - All payloads stay stable while the corresponding valid is high.
  - Both handshakes in the same cycle is legal and completes the burst.
  - When both are done: cur_addr += beats*B and rem -= beats; clear the flags.
  - If rem==0: pulse chn_done[cur_chn] for one cycle and go to IDLE. Otherwise go to CALC.
- Per descriptor, bursts are issued in address order with no interleaving of other channels. Arbitration happens only in IDLE.
- No outstanding-transaction limit is enforced here. Backpressure on atx_rdy (ROB/FIFO full in the R stage) throttles issue.
- A misaligned req_addr is a caller error; the low address bits are passed through unchanged.
- req_len values that would wrap the address space are not checked.

Test Plan:
- B=32. ch0 addr 0x1000, len 40 → three bursts (ARADDR/ARLEN) 0x1000/15, 0x1200/15, 0x1400/7; atx_chn_id=0 each time; chn_done[0] pulses once, after the third handshake.
- ch1 addr 0x1F80, len 10 → 0x1F80/3, then 0x2000/5; no burst crosses 0x2000.
- After reset, ch0 and ch2 valid together (len 1 each) → ch0 granted first, then ch2. Then ch0 and ch1 valid → ch0 granted (pointer at 3 wraps to 0), then ch1.
- atx_rdy=1, m_arready_i held 0 for 5 cycles → atx_vld high for exactly 1 cycle, then low. AR payload is stable for 5 cycles. After ARREADY, the next burst's valids rise two cycles later (CALC, then ISSUE).
- rst asserted while m_arvalid_o=1 mid-descriptor → m_arvalid_o, atx_vld and req_rdy are 0 in the same cycle. After release, no AR appears until a new req_vld.
- ch3 len 0 → req_rdy[3] handshake, chn_done[3] pulse next cycle, no m_arvalid_o/atx_vld activity.
